// File: rtl/wbm_cmd_master_pkg.sv
// Shared types for the Wishbone command master: FSM state encoding and the
// response status codes returned on rsp_status_o.
package wbm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } wbm_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUSERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/wbm_cmd_master_if.sv
// Command, response and Wishbone signal bundle of the command master.
// The master modport is the DUT view; slave is the host/interconnect side.
interface wbm_cmd_master_if #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int BYTE_EN_WIDTH  = BUS_DATA_WIDTH / 8
);

  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic                      cmd_we_i;
  logic [BYTE_EN_WIDTH-1:0]  cmd_sel_i;
  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i;
  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i;

  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [BUS_DATA_WIDTH-1:0] rsp_dat_o;
  logic [1:0]                rsp_status_o;

  logic                      wbm_cyc_o;
  logic                      wbm_stb_o;
  logic                      wbm_we_o;
  logic [BYTE_EN_WIDTH-1:0]  wbm_sel_o;
  logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o;
  logic [BUS_DATA_WIDTH-1:0] wbm_dat_o;
  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i;
  logic                      wbm_ack_i;
  logic                      wbm_err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
    input  rsp_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
    output rsp_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface

// File: rtl/wbm_cmd_master_timeout.sv
// Saturating, loadable up-counter for the bus-cycle timeout. o_tc is high
// when the increment taken on the coming edge reaches TIMEOUT.
module wbm_timeout #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign o_tc      = i_en && (w_cnt_inc >= (CNT_W + 1)'(TIMEOUT));

  // Counter state: clear wins over load, which wins over the saturating increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/wbm_cmd_master.sv
// Wishbone classic single-transfer master: each accepted command runs one bus
// cycle, and its outcome (ok / bus error / timeout) is returned on rsp_*.
module wbm_cmd_master
  import wbm_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int TIMEOUT        = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wbm_cmd_master_if.master bus
);

  localparam int BYTE_EN_WIDTH = BUS_DATA_WIDTH / 8;
  localparam int CNT_W         = $clog2(TIMEOUT + 1);

  wbm_state_e                r_state;
  wbm_state_e                w_state_nxt;

  logic                      r_cmd_ready;
  logic                      r_cyc;
  logic                      r_we;
  logic [BYTE_EN_WIDTH-1:0]  r_sel;
  logic [BUS_ADDR_WIDTH-1:0] r_adr;
  logic [BUS_DATA_WIDTH-1:0] r_dat;
  logic                      r_rsp_valid;
  logic [BUS_DATA_WIDTH-1:0] r_rsp_dat;
  logic [1:0]                r_rsp_status;

  logic                      w_cmd_hs;
  logic                      w_in_bus;
  logic                      w_tc;
  logic                      w_bus_done;
  logic                      w_cmd_ready_nxt;
  logic                      w_cyc_nxt;
  logic                      w_rsp_valid_nxt;
  logic [BUS_DATA_WIDTH-1:0] w_rsp_dat_nxt;
  logic [1:0]                w_rsp_status_nxt;

  // r_cmd_ready rather than the state is used so nothing is taken in the cycle after reset release
  assign w_cmd_hs   = (r_state == S_IDLE) && bus.cmd_valid_i && r_cmd_ready;
  assign w_in_bus   = (r_state == S_BUS);
  assign w_bus_done = w_in_bus && (bus.wbm_err_i || bus.wbm_ack_i || w_tc);

  wbm_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .i_clk      (wb_clk_i),
    .i_rst_n    (wb_rst_i),
    .i_clr      (w_cmd_hs),
    .i_load     (1'b0),
    .i_load_val ({CNT_W{1'b0}}),
    .i_en       (w_in_bus),
    .o_tc       (w_tc)
  );

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) w_state_nxt = S_BUS;
        else          w_state_nxt = S_IDLE;
      end
      S_BUS: begin
        if (w_bus_done) w_state_nxt = S_RESP;
        else            w_state_nxt = S_BUS;
      end
      S_RESP: begin
        if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
        else                 w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    w_cmd_ready_nxt  = (w_state_nxt == S_IDLE);
    w_cyc_nxt        = (w_state_nxt == S_BUS);
    w_rsp_valid_nxt  = (w_state_nxt == S_RESP);
    w_rsp_dat_nxt    = r_rsp_dat;
    w_rsp_status_nxt = r_rsp_status;
    if (w_bus_done) begin
      if (bus.wbm_err_i) begin
        w_rsp_status_nxt = ST_BUSERR;
        w_rsp_dat_nxt    = {BUS_DATA_WIDTH{1'b0}};
      end else if (bus.wbm_ack_i) begin
        w_rsp_status_nxt = ST_OK;
        w_rsp_dat_nxt    = r_we ? {BUS_DATA_WIDTH{1'b0}} : bus.wbm_dat_i;
      end else begin
        w_rsp_status_nxt = ST_TIMEOUT;
        w_rsp_dat_nxt    = {BUS_DATA_WIDTH{1'b0}};
      end
    end else begin
      w_rsp_status_nxt = r_rsp_status;
      w_rsp_dat_nxt    = r_rsp_dat;
    end
  end

  // Control and response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_cmd_ready  <= 1'b0;
      r_cyc        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= {BUS_DATA_WIDTH{1'b0}};
      r_rsp_status <= ST_OK;
    end else begin
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_cyc        <= w_cyc_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_dat    <= w_rsp_dat_nxt;
      r_rsp_status <= w_rsp_status_nxt;
    end
  end

  // Request registers: captured on command acceptance, held for the whole bus cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_we  <= 1'b0;
      r_sel <= {BYTE_EN_WIDTH{1'b0}};
      r_adr <= {BUS_ADDR_WIDTH{1'b0}};
      r_dat <= {BUS_DATA_WIDTH{1'b0}};
    end else if (w_cmd_hs) begin
      r_we  <= bus.cmd_we_i;
      r_sel <= bus.cmd_sel_i;
      r_adr <= bus.cmd_adr_i;
      r_dat <= bus.cmd_dat_i;
    end else begin
      r_we  <= r_we;
      r_sel <= r_sel;
      r_adr <= r_adr;
      r_dat <= r_dat;
    end
  end

  assign bus.cmd_ready_o  = r_cmd_ready;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_dat_o    = r_rsp_dat;
  assign bus.rsp_status_o = r_rsp_status;
  assign bus.wbm_cyc_o    = r_cyc;
  assign bus.wbm_stb_o    = r_cyc;
  assign bus.wbm_we_o     = r_we;
  assign bus.wbm_sel_o    = r_sel;
  assign bus.wbm_adr_o    = r_adr;
  assign bus.wbm_dat_o    = r_dat;

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Bench for wbm_cmd_master: slave with registers at 0x04-0x0B plus a
// byte-lane memory reference model; directed scenarios then random traffic.
module tb_wbm_cmd_master;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wbm_cmd_master_if #(.BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(8)) bus ();

  wbm_cmd_master #(
    .BUS_DATA_WIDTH (32),
    .BUS_ADDR_WIDTH (8),
    .TIMEOUT        (TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  // Slave: mapped registers ack after sl_dly wait cycles; error mode raises err and ack together.
  int          sl_cnt = 0;
  int          sl_dly = 0;
  bit          sl_err = 1'b0;
  bit          sl_stray = 1'b0;
  logic [31:0] sl_mem [8] = '{default: 32'h0};
  logic        sl_sel;
  logic        sl_map;
  logic [2:0]  sl_idx;

  assign sl_sel = bus.wbm_cyc_o && bus.wbm_stb_o;
  assign sl_map = (bus.wbm_adr_o >= 8'h04) && (bus.wbm_adr_o <= 8'h0B);
  assign sl_idx = 3'(bus.wbm_adr_o - 8'h04);
  assign bus.wbm_err_i = (sl_sel && sl_err && (sl_cnt == sl_dly)) || sl_stray;
  assign bus.wbm_ack_i = (sl_sel && (sl_map || sl_err) && (sl_cnt == sl_dly)) || sl_stray;
  assign bus.wbm_dat_i = sl_map ? sl_mem[sl_idx] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (sl_sel && !(bus.wbm_ack_i || bus.wbm_err_i)) sl_cnt <= sl_cnt + 1;
    else                                             sl_cnt <= 0;
    if (sl_sel && bus.wbm_ack_i && !bus.wbm_err_i && bus.wbm_we_o && sl_map)
      for (int b = 0; b < 4; b++)
        if (bus.wbm_sel_o[b]) sl_mem[sl_idx][8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
  end

  logic [31:0] ref_mem [8] = '{default: 32'h0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete command/response transaction with reference-model expectations.
  task automatic txn(input bit we, input logic [3:0] sel, input logic [7:0] adr,
                     input logic [31:0] dat, input int dly, input bit err,
                     input int bp, input bit pend, output logic [31:0] rd);
    bit          mapped;
    logic [1:0]  e_st;
    logic [31:0] e_dat;
    int          e_len;
    int          n;
    int          len;
    logic [1:0]  st0;
    logic [31:0] d0;
    mapped = (adr >= 8'h04) && (adr <= 8'h0B);
    e_dat  = 32'h0;
    if (err) begin
      e_st = 2'b01; e_len = dly + 1;
    end else if (mapped) begin
      e_st = 2'b00; e_len = dly + 1;
      if (!we) e_dat = ref_mem[adr - 8'h04];
      else
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[adr - 8'h04][8*b +: 8] = dat[8*b +: 8];
    end else begin
      e_st = 2'b10; e_len = TO;
    end

    @(negedge clk);
    sl_dly = dly; sl_err = err;
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = we; bus.cmd_sel_i = sel;
    bus.cmd_adr_i = adr; bus.cmd_dat_i = dat;
    n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 64'(n < 50), 64'd1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("bus_req", {bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o,
                    bus.wbm_stb_o, bus.cmd_ready_o},
                   {we, sel, adr, dat, 1'b1, 1'b0});
    len = 0;
    while (bus.wbm_cyc_o === 1'b1 && len < 400) begin len++; @(negedge clk); end
    chk("cyc_len", 64'(len), 64'(e_len));
    chk("rsp_valid", {bus.rsp_valid_o, bus.wbm_cyc_o, bus.wbm_stb_o}, 3'b100);
    st0 = bus.rsp_status_o; d0 = bus.rsp_dat_o;
    for (int i = 0; i < bp; i++) begin
      if (pend) begin
        bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = 8'h04;
      end
      @(negedge clk);
      chk("rsp_hold", {bus.rsp_valid_o, bus.rsp_status_o, bus.rsp_dat_o,
                       bus.cmd_ready_o, bus.wbm_cyc_o},
                      {1'b1, st0, d0, 1'b0, 1'b0});
    end
    chk("rsp_status", 64'(bus.rsp_status_o), 64'(e_st));
    chk("rsp_dat", 64'(bus.rsp_dat_o), 64'(e_dat));
    rd = bus.rsp_dat_o;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("post_rsp", {bus.rsp_valid_o, bus.cmd_ready_o, bus.wbm_cyc_o}, 3'b010);
    bus.cmd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_sel_i = 4'h0;
    bus.cmd_adr_i = 8'h00; bus.cmd_dat_i = 32'h0; bus.rsp_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outs", {bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_status_o,
                       bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                       bus.wbm_adr_o}, 64'h0);
    chk("reset_wdat", 64'(bus.wbm_dat_o), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_clk", 64'(bus.cmd_ready_o), 64'd0);
    @(negedge clk);
    chk("ready_after_clk", 64'(bus.cmd_ready_o), 64'd1);

    // Stray ack/err while idle must not start a response.
    sl_stray = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack", {bus.rsp_valid_o, bus.wbm_cyc_o, bus.cmd_ready_o}, 3'b001);
    sl_stray = 1'b0;

    // 1: fastest write then read-back.
    txn(1'b1, 4'hF, 8'h04, 32'hEEEEEEEE, 0, 1'b0, 0, 1'b0, rd);
    txn(1'b0, 4'hF, 8'h04, 32'h0, 0, 1'b0, 0, 1'b0, rd);
    chk("t1_readback", 64'(rd), 64'hEEEEEEEE);

    // 2: partial byte-lane write over an existing value.
    txn(1'b1, 4'hF, 8'h05, 32'hEEEEEEEF, 1, 1'b0, 0, 1'b0, rd);
    txn(1'b1, 4'b0101, 8'h05, 32'h11223344, 0, 1'b0, 0, 1'b0, rd);
    txn(1'b0, 4'hF, 8'h05, 32'h0, 2, 1'b0, 0, 1'b0, rd);
    chk("t2_readback", 64'(rd), 64'hEE22EE44);

    // 3: unmapped read times out after exactly TO cycles.
    txn(1'b0, 4'hF, 8'h40, 32'h0, 0, 1'b0, 0, 1'b0, rd);

    // 4: err together with ack.
    txn(1'b0, 4'hF, 8'h08, 32'h0, 0, 1'b1, 0, 1'b0, rd);

    // 5: backpressure with a pending command.
    txn(1'b1, 4'hF, 8'h06, 32'hA5A5_5A5A, 0, 1'b0, 0, 1'b0, rd);
    txn(1'b0, 4'hF, 8'h06, 32'h0, 1, 1'b0, 10, 1'b1, rd);
    chk("t5_readback", 64'(rd), 64'hA5A55A5A);

    // 6: asynchronous reset while the slave stalls.
    @(negedge clk);
    sl_dly = 100; sl_err = 1'b0;
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b0; bus.cmd_sel_i = 4'hF;
    bus.cmd_adr_i = 8'h07; bus.cmd_dat_i = 32'h0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_in_bus", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_drop", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, bus.cmd_ready_o}, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_rel", {bus.cmd_ready_o, bus.rsp_valid_o, bus.wbm_cyc_o}, 3'b100);
    txn(1'b1, 4'hF, 8'h07, 32'h1357_9BDF, 0, 1'b0, 0, 1'b0, rd);
    txn(1'b0, 4'hF, 8'h07, 32'h0, 0, 1'b0, 1, 1'b0, rd);
    chk("t6_readback", 64'(rd), 64'h13579BDF);

    // Random traffic against the reference model.
    for (int k = 0; k < 30; k++) begin
      txn(1'($urandom % 2), 4'($urandom), 8'($urandom_range(2, 13)), $urandom,
          int'($urandom_range(0, 3)), ($urandom % 8) == 0,
          int'($urandom_range(0, 3)), 1'($urandom % 2), rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
